uart_rx: RTL and testbench

Serial receiver for the UART link: the counterpart of the existing UART transmitter (`P_DATA`/`PAR_EN`/`PAR_TYP`/`DATA_VALID`/`TX_OUT`/`Busy`). It oversamples `RX_IN` at `PRESCALE` clocks per bit and detects the start bit. It deframes LSB-first data with optional parity, then reports each frame as a one-cycle `DATA_VALID` pulse or as a parity/stop error. It sits between the pad/loopback of `TX_OUT` and the system-side consumer. The loopback bench reuses it as the reference receiver.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sampler.sv | 73 +++++++
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity encodings and the
// parity helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity bit for up to 32 data bits; callers zero-extend narrower words.
  function automatic logic parity_bit(input logic [31:0] data, input logic par_typ);
    return (^data) ^ par_typ;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchronizer, per-bit edge counter and bit sampler.
// UART_RX_MAJORITY_VOTE_EN selects a 3-sample majority vote taken one cycle later.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  input  logic active,
  output logic rx_s,
  output logic sample_valid,
  output logic sample_bit,
  output logic bit_end
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] SP   = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] edge_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
    end
  end

  assign rx_s = sync2;

  // The counter runs only while a frame is in progress, so it reads 1 on the
  // first cycle after start detection and 0 whenever the receiver is idle.
  always_ff @(posedge clk) begin
    if (reset || !active) begin
      edge_cnt <= '0;
    end else if (edge_cnt == LAST) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  assign bit_end = (edge_cnt == LAST);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] SP_LATE = CW'(PRESCALE / 2 + 1);

  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  // hist[1] holds rx_s at SP-1 and hist[0] at SP when edge_cnt reaches SP+1.
  assign sample_valid = (edge_cnt == SP_LATE);
  assign sample_bit   = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign sample_valid = (edge_cnt == SP);
  assign sample_bit   = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, LSB-first deframing, optional parity and
// stop checking. Build option: UART_RX_MAJORITY_VOTE_EN (3-sample majority).
module uart_rx
  import uart_pkg::*;
#(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_state_t           state_q;
  uart_state_t           state_d;
  logic                  rx_s;
  logic                  sample_valid;
  logic                  sample_bit;
  logic                  bit_end;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  bad_q;
  logic                  stop_done_q;
  logic [31:0]           data_ext;
  logic                  par_exp;
  logic                  dv_d;
  logic                  pe_d;
  logic                  se_d;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk         (clk),
    .reset       (reset),
    .rx_in       (RX_IN),
    .active      (state_d != IDLE),
    .rx_s        (rx_s),
    .sample_valid(sample_valid),
    .sample_bit  (sample_bit),
    .bit_end     (bit_end)
  );

  always_comb begin
    data_ext                 = '0;
    data_ext[DATA_WIDTH-1:0] = shift_q;
    par_exp                  = parity_bit(data_ext, par_typ_q);
  end

  // DATA_VALID, PAR_ERR and STP_ERR are single-cycle registered pulses with no
  // back-pressure; P_DATA is only meaningful in the DATA_VALID cycle and holds after.
  always_comb begin
    state_d = state_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    se_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (sample_valid && sample_bit) state_d = IDLE;
        else if (bit_end)               state_d = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == LAST_BIT)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (sample_valid && (sample_bit != par_exp)) pe_d = 1'b1;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Hold one extra cycle so Busy covers the cycle in which the pulse shows.
        if (stop_done_q) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          if (!sample_bit) se_d = 1'b1;
          else if (!bad_q) dv_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      bad_q       <= 1'b0;
      stop_done_q <= 1'b0;
      P_DATA      <= '0;
      DATA_VALID  <= 1'b0;
      PAR_ERR     <= 1'b0;
      STP_ERR     <= 1'b0;
    end else begin
      state_q     <= state_d;
      DATA_VALID  <= dv_d;
      PAR_ERR     <= pe_d;
      STP_ERR     <= se_d;
      stop_done_q <= (state_q == STOP) && sample_valid;
      if (dv_d) P_DATA <= shift_q;
      if (pe_d) bad_q <= 1'b1;
      if (state_q == IDLE) begin
        bit_cnt <= '0;
        bad_q   <= 1'b0;
        if (!rx_s) begin
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
        end
      end
      if (state_q == DATA) begin
        if (sample_valid) shift_q <= {sample_bit, shift_q[DATA_WIDTH-1:1]};
        if (bit_end)      bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit, a reference
// model predicts each pulse and its cycle, and a monitor checks against it.
module tb_uart_rx;

  localparam int P  = 8;
  localparam int SP = P / 2;
  localparam int DW = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  localparam logic [1:0] K_DV  = 2'd0;
  localparam logic [1:0] K_PAR = 2'd1;
  localparam logic [1:0] K_STP = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;
  logic          Busy;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic [7:0] model_pdata = 8'h00;

  uart_rx #(.PRESCALE(P), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR),
    .Busy      (Busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cycle(input int target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
  endtask

  // Must be called just after a rising edge (+1); returns the same way, so
  // consecutive calls produce back-to-back frames.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic par_bad, input logic stop_val, input int flip_bit);
    int   t;
    int   nb;
    int   n;
    logic par;
    logic [11:0] bits;
    exp_t e;
    t       = cyc;
    PAR_EN  = pe;
    PAR_TYP = pt;
    par     = (^d) ^ pt;
    bits    = '0;
    for (int i = 0; i < DW; i++) bits[1+i] = d[i];
    nb = 1 + DW;
    if (pe) begin
      bits[nb] = par ^ par_bad;
      nb++;
    end
    bits[nb] = stop_val;
    nb++;
    n = 1 + DW + (pe ? 1 : 0);
    if (pe && par_bad) begin
      e.kind = K_PAR; e.data = 8'h00; e.cyc = 32'(t + 3 + (1 + DW) * P + SP + MAJ);
      exp_q.push_back(e);
    end
    if (!stop_val) begin
      e.kind = K_STP; e.data = 8'h00; e.cyc = 32'(t + 3 + n * P + SP + MAJ);
      exp_q.push_back(e);
    end else if (!(pe && par_bad)) begin
      e.kind = K_DV; e.data = d; e.cyc = 32'(t + 3 + n * P + SP + MAJ);
      exp_q.push_back(e);
      model_pdata = d;
    end
    for (int k = 0; k < nb; k++) begin
      if (k == 3) begin
        PAR_EN  = ~pe;
        PAR_TYP = ~pt;
      end
      for (int j = 0; j < P; j++) begin
        RX_IN = (k == flip_bit && j == SP) ? ~bits[k] : bits[k];
        @(posedge clk);
        #1;
      end
    end
    RX_IN = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] kind;
    int         npulse;
    npulse = int'(DATA_VALID) + int'(PAR_ERR) + int'(STP_ERR);
    if (npulse > 0) begin
      check("one_pulse_per_cycle", 32'(npulse), 32'd1);
      kind = DATA_VALID ? K_DV : (PAR_ERR ? K_PAR : K_STP);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse at cycle %0d: kind=%0d P_DATA=%0h", cyc, kind, P_DATA);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'(kind), 32'(e.kind));
        check("pulse_cycle", 32'(cyc), e.cyc);
        check("busy_at_pulse", 32'(Busy), 32'd1);
        if (e.kind == K_DV) check("p_data", 32'(P_DATA), 32'(e.data));
      end
    end
  end

  task automatic check_quiet(input string name);
    @(negedge clk);
    check({name, "_busy"}, 32'(Busy), 32'd0);
    check({name, "_p_data"}, 32'(P_DATA), 32'(model_pdata));
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    reset   = 1'b1;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p_data", 32'(P_DATA), 32'h0);
    check("rst_data_valid", 32'(DATA_VALID), 32'd0);
    check("rst_par_err", 32'(PAR_ERR), 32'd0);
    check("rst_stp_err", 32'(STP_ERR), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);

    // good frame, even parity
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle(2 * P);
    check_quiet("good_even");

    // odd parity error: P_DATA keeps 0xA5
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    idle(2 * P);
    check_quiet("par_err");

    // stop error, no parity
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(3 * P);
    check_quiet("stp_err");

    // both errors in one frame
    send_frame(8'h96, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    idle(3 * P);
    check_quiet("both_err");

    // start glitch: low for 3 cycles
    t = cyc;
    RX_IN = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    RX_IN = 1'b1;
    wait_cycle(t + 3);
    check("glitch_busy_high", 32'(Busy), 32'd1);
    wait_cycle(t + 2 + SP + MAJ);
    check("glitch_busy_still_high", 32'(Busy), 32'd1);
    wait_cycle(t + 3 + SP + MAJ);
    check("glitch_busy_low", 32'(Busy), 32'd0);
    @(posedge clk);
    #1;
    idle(P);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(2 * P);
    check_quiet("after_glitch");

    // back-to-back
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(2 * P);
    check_quiet("back_to_back");

    // reset during the 4th data bit
    PAR_EN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      RX_IN = (k == 0) ? 1'b0 : k[0];
      for (int j = 0; j < ((k == 4) ? SP : P); j++) begin
        @(posedge clk);
        #1;
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    RX_IN = 1'b1;
    model_pdata = 8'h00;
    @(negedge clk);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_p_data", 32'(P_DATA), 32'h0);
    check("midrst_pulses", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'h0);
    @(posedge clk);
    #1;
    idle(2 * P);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    idle(2 * P);
    check_quiet("after_reset");

`ifdef UART_RX_MAJORITY_VOTE_EN
    // one-cycle inversion at the centre of data bit 3
    send_frame(8'h6B, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    idle(2 * P);
    check_quiet("majority_flip");
`endif

    // randomized frames against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      logic       pe;
      logic       pt;
      logic       pb;
      logic       sv;
      d  = 8'($urandom_range(0, 255));
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      pb = pe && ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 4) != 0);
      send_frame(d, pe, pt, pb, sv, -1);
      if (!sv) idle(3 * P);
      else idle($urandom_range(0, 3));
    end
    idle(3 * P);
    check_quiet("random_end");

    check("missing_pulses", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
